// File: rtl/shared_fifo_reader_pkg.sv
// Shared definitions for the linked-list FIFO reader and its proof tops:
// reader FSM state encoding and a modulo-N index increment.
package shared_fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Explicit wrap so non-power-of-two FIFO counts step correctly.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/shared_fifo_reader_skid.sv
// Two-entry tagged output buffer: words leave in push order, simultaneous
// push and pop is allowed even when full.
module tagged_skid_buffer #(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic [SEL_WIDTH-1:0] push_tag,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [WIDTH-1:0]     head_data,
  output logic [SEL_WIDTH-1:0] head_tag
);

  logic [WIDTH-1:0]     data_mem [2];
  logic [SEL_WIDTH-1:0] tag_mem  [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic [1:0]           count_next;
  logic                 push_ok;
  logic                 pop_ok;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count <= count_next;
    end
  end

  // When full, wr_ptr aliases rd_ptr; a same-edge pop frees that slot first.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_mem[wr_ptr] <= push_data;
      tag_mem[wr_ptr]  <= push_tag;
    end
  end

  // Storage is not reset, so the head is forced to zero while empty.
  assign head_data = empty ? '0 : data_mem[rd_ptr];
  assign head_tag  = empty ? '0 : tag_mem[rd_ptr];

endmodule

// File: rtl/shared_fifo_reader.sv
// Round-robin reader for a shared linked-list FIFO: picks a non-empty FIFO,
// pops it and forwards {word, source index} through a 2-entry output buffer.
module shared_fifo_reader
  import shared_fifo_reader_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 pop,
  output logic [SEL_WIDTH-1:0] pop_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_tag,
  output logic                 busy
);

  state_t               state;
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] found_sel;
  logic [SEL_WIDTH-1:0] scan;
  logic                 found;
  logic                 buf_full;
  logic                 buf_empty;
  logic                 xfer;
  logic                 space;
  logic                 pop_fire;
  logic                 drain_done;

  always_comb begin
    found     = 1'b0;
    found_sel = rr_ptr;
    scan      = rr_ptr;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      if (!found && !fifo_empty[scan]) begin
        found     = 1'b1;
        found_sel = scan;
      end
      scan = SEL_WIDTH'(next_idx(32'(scan), unsigned'(NUM_FIFOS)));
    end
  end

  assign xfer      = out_valid && out_ready;
  assign space     = !buf_full || xfer;
  assign pop_fire  = (state == RUN) && found && space;
  assign pop       = pop_fire;
  assign pop_sel   = pop_fire ? found_sel : rr_ptr;
  assign out_valid = !buf_empty;
  assign busy      = (state != IDLE);

  // No pushes outside RUN, so the buffer empties once one entry remains and leaves.
  assign drain_done = buf_empty || (!buf_full && xfer);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      if (pop_fire) rr_ptr <= SEL_WIDTH'(next_idx(32'(found_sel), unsigned'(NUM_FIFOS)));
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= buf_empty ? IDLE : DRAIN;
        DRAIN: begin
          if (enable)          state <= RUN;
          else if (drain_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  tagged_skid_buffer #(
    .WIDTH    (WIDTH),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (pop_fire),
    .push_data(fifo_data),
    .push_tag (found_sel),
    .pop      (xfer),
    .full     (buf_full),
    .empty    (buf_empty),
    .head_data(out_data),
    .head_tag (out_tag)
  );

endmodule

// File: tb/tb_shared_fifo_reader.sv
// Bench for shared_fifo_reader: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_shared_fifo_reader;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] fifo_empty;
  logic [7:0] fifo_data;
  logic       pop;
  logic       pop_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_tag;
  logic       busy;

  int checks = 0;
  int errors = 0;

  shared_fifo_reader #(.WIDTH(8), .NUM_FIFOS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .pop       (pop),
    .pop_sel   (pop_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] fe;
    logic [7:0] din;
    logic       rdy;
    logic       e_pop;
    logic       e_sel;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_tag;
    logic       e_busy;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       t;
  } ent_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] fe, input logic [7:0] din, input logic rdy);
    enable     = en;
    fifo_empty = fe;
    fifo_data  = din;
    out_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 2'b11, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Reference model state (mode: 0 idle, 1 run, 2 drain).
  int   m_mode;
  int   m_rr;
  ent_t m_q [$];

  initial begin
    rst = 1'b0;
    drive(1'b0, 2'b11, 8'h00, 1'b0);
    #2;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_pop",   32'(pop),       32'd0);
    check("reset_busy",  32'(busy),      32'd0);
    check("reset_data",  32'(out_data),  32'd0);

    // Round robin, skip-empty and short drains from a fresh reset.
    tbl[0]  = '{1'b1, 2'b00, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'b00, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 2'b00, 8'h12, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 2'b00, 8'h13, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 2'b00, 8'h14, 1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 2'b11, 8'h15, 1'b1, 1'b0, 1'b0, 1'b1, 8'h14, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 2'b11, 8'h16, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 2'b11, 8'h17, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'b01, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2'b01, 8'h21, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 2'b11, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 2'b10, 8'h23, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 2'b11, 8'h24, 1'b1, 1'b0, 1'b1, 1'b1, 8'h23, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 2'b11, 8'h25, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 2'b11, 8'h26, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].en, tbl[i].fe, tbl[i].din, tbl[i].rdy);
      @(negedge clk);
      check($sformatf("tbl%0d_pop", i),   32'(pop),       32'(tbl[i].e_pop));
      check($sformatf("tbl%0d_sel", i),   32'(pop_sel),   32'(tbl[i].e_sel));
      check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_data", i),  32'(out_data),  32'(tbl[i].e_data));
      check($sformatf("tbl%0d_tag", i),   32'(out_tag),   32'(tbl[i].e_tag));
      check($sformatf("tbl%0d_busy", i),  32'(busy),      32'(tbl[i].e_busy));
      tick();
    end

    // Backpressure: two pops fill the buffer, then the head holds.
    do_reset();
    drive(1'b1, 2'b00, 8'h00, 1'b0);
    tick();
    drive(1'b1, 2'b00, 8'hA5, 1'b0);
    @(negedge clk);
    check("bp_pop1", 32'(pop), 32'd1);
    check("bp_sel1", 32'(pop_sel), 32'd0);
    tick();
    drive(1'b1, 2'b00, 8'h5A, 1'b0);
    @(negedge clk);
    check("bp_pop2", 32'(pop), 32'd1);
    check("bp_sel2", 32'(pop_sel), 32'd1);
    check("bp_head", 32'(out_data), 32'hA5);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 8'h77, 1'b0);
      @(negedge clk);
      check("bp_hold_pop", 32'(pop), 32'd0);
      check("bp_hold_data", 32'(out_data), 32'hA5);
      check("bp_hold_tag", 32'(out_tag), 32'd0);
      tick();
    end
    drive(1'b1, 2'b11, 8'h77, 1'b1);
    @(negedge clk);
    check("bp_out1", 32'(out_data), 32'hA5);
    tick();
    @(negedge clk);
    check("bp_out2", 32'(out_data), 32'h5A);
    check("bp_out2_tag", 32'(out_tag), 32'd1);
    tick();
    @(negedge clk);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Drain: enable drops with a full buffer while FIFOs still hold data.
    do_reset();
    drive(1'b1, 2'b00, 8'h00, 1'b0);
    tick();
    drive(1'b1, 2'b00, 8'h31, 1'b0);
    tick();
    drive(1'b1, 2'b00, 8'h32, 1'b0);
    tick();
    drive(1'b0, 2'b00, 8'h33, 1'b0);
    @(negedge clk);
    check("dr_full_pop", 32'(pop), 32'd0);
    tick();
    drive(1'b0, 2'b00, 8'h34, 1'b1);
    @(negedge clk);
    check("dr_pop_a", 32'(pop), 32'd0);
    check("dr_busy_a", 32'(busy), 32'd1);
    check("dr_data_a", 32'(out_data), 32'h31);
    tick();
    @(negedge clk);
    check("dr_pop_b", 32'(pop), 32'd0);
    check("dr_busy_b", 32'(busy), 32'd1);
    check("dr_data_b", 32'(out_data), 32'h32);
    tick();
    @(negedge clk);
    check("dr_idle_busy", 32'(busy), 32'd0);
    check("dr_idle_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-run with a full buffer and rr_ptr at 1.
    do_reset();
    drive(1'b1, 2'b10, 8'h00, 1'b0);
    tick();
    drive(1'b1, 2'b10, 8'h41, 1'b0);
    tick();
    drive(1'b1, 2'b10, 8'h42, 1'b0);
    @(negedge clk);
    check("rs_fill_sel", 32'(pop_sel), 32'd0);
    check("rs_fill_valid", 32'(out_valid), 32'd1);
    tick();
    drive(1'b1, 2'b00, 8'h43, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_pop", 32'(pop), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_sel", 32'(pop_sel), 32'd0);
    check("rs_data", 32'(out_data), 32'd0);
    check("rs_tag", 32'(out_tag), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rs_first_pop", 32'(pop), 32'd0);
    tick();
    @(negedge clk);
    check("rs_run_pop", 32'(pop), 32'd1);
    check("rs_run_sel", 32'(pop_sel), 32'd0);
    check("rs_discard", 32'(out_valid), 32'd0);

    // Randomized run against the reference model.
    do_reset();
    m_mode = 0;
    m_rr   = 0;
    m_q.delete();
    begin
      logic       en;
      logic [1:0] fe;
      logic [7:0] din;
      logic       rdy;
      logic       ev;
      logic [7:0] ed;
      logic       et;
      logic       ep;
      int         es;
      int         pre_size;
      en = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if ($urandom_range(0, 15) == 0) en = ~en;
        fe  = 2'($urandom_range(0, 3));
        din = 8'($urandom);
        rdy = ($urandom_range(0, 3) != 0);
        drive(en, fe, din, rdy);

        ev = (m_q.size() != 0);
        ed = ev ? m_q[0].d : 8'h00;
        et = ev ? m_q[0].t : 1'b0;
        ep = (m_mode == 1) && (fe != 2'b11) && ((m_q.size() < 2) || (ev && rdy));
        es = m_rr;
        if (ep) begin
          for (int k = 1; k >= 0; k--) begin
            int c;
            c = (m_rr + k) % 2;
            if (!fe[c[0]]) es = c;
          end
        end

        @(negedge clk);
        check("rnd_pop",   32'(pop),       32'(ep));
        check("rnd_sel",   32'(pop_sel),   32'(es));
        check("rnd_valid", 32'(out_valid), 32'(ev));
        check("rnd_data",  32'(out_data),  32'(ed));
        check("rnd_tag",   32'(out_tag),   32'(et));
        check("rnd_busy",  32'(busy),      32'(m_mode != 0));
        @(posedge clk);

        pre_size = m_q.size();
        if (ev && rdy) void'(m_q.pop_front());
        if (ep) begin
          m_q.push_back('{d: din, t: es[0]});
          m_rr = (es + 1) % 2;
        end
        case (m_mode)
          0: if (en) m_mode = 1;
          1: if (!en) m_mode = (pre_size != 0) ? 2 : 0;
          default: begin
            if (en) m_mode = 1;
            else if (m_q.size() == 0) m_mode = 0;
          end
        endcase
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
